sequence_transmitter: RTL and testbench
=======================================

# sequence_transmitter

Serial pattern generator: the transmit-side counterpart of the team's serial sequence detector. On a `start` request it latches a WIDTH-bit pattern and shifts it out MSB-first on a single serial line, one bit per clock. It can repeat the pattern a programmable number of times, separated by idle gaps. It produces the stimulus stream for the detector in loopback and in system tests; the line idles high.

## Interface
- `WIDTH`, default 4: pattern length in bits; must be ≥ 2.
- `CNT_W`, default 4: width of the repeat-count input.
- `GAP_BITS`, default 2: idle-high bits inserted between repetitions; 0 allowed, meaning back-to-back frames.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: transmit request; sampled on the rising edge; accepted only when `busy`=0.
- `pattern` input WIDTH: bits to send, MSB first; latched on acceptance.
- `repeat_cnt` input CNT_W: number of extra repetitions; total frames = `repeat_cnt`+1; latched on acceptance.
- `out` output 1: serial data, registered; idle level 1.
- `busy` output 1: registered; high from the cycle after acceptance through the last transmitted bit.
- `done` output 1: registered one-cycle pulse in the cycle after the last bit.

## Operation
- Reset values: `out`=1, `busy`=0, `done`=0, state IDLE, counters 0.
- States:
  - IDLE: `out`=1; `start`=1 → latch `pattern`/`repeat_cnt` → SEND.
  - SEND: `out` = current MSB of the shift register; shift left each cycle; bit counter runs 0..WIDTH-1. After the last bit:
    - frames remaining and GAP_BITS>0 → GAP;
    - frames remaining and GAP_BITS=0 → reload pattern, stay in SEND;
    - no frames remaining → IDLE with `done`=1.
  - GAP: `out`=1 for exactly GAP_BITS cycles; then reload the latched pattern → SEND.
- Frame counter decrements once per completed frame. It is compared against the latched copy, never against the live `repeat_cnt`.
- `start` while `busy`=1 is ignored. Changes to `pattern` or `repeat_cnt` while `busy` have no effect.
- `start` is accepted in the `done` cycle, giving back-to-back transfers with one idle-high bit between them.
- `rst` mid-transfer: on the next edge, all outputs return to reset values and the transfer is dropped. No `done` pulse.
- `rst` and `start` in the same cycle: `rst` wins; `start` is not accepted.
- `repeat_cnt` = all-ones: 2^CNT_W frames. The counter must not wrap early.

## Timing
- Acceptance at edge t. First bit on `out` and `busy`=1 during cycle t+1. Latency is 1 cycle.
- Single frame: bits occupy cycles t+1..t+WIDTH; `done`=1 and `busy`=0 in cycle t+WIDTH+1.
- N = `repeat_cnt`+1 frames: total busy cycles = N·WIDTH + (N−1)·GAP_BITS. `done` is asserted in the cycle after the last busy cycle.
- `out` changes only on clock edges and is glitch-free (driven directly from a register).

## Structure
- Shared package `seq_pkg` holds:
  - state encoding constants `IDLE`, `SEND`, `GAP` (2-bit);
  - `LINE_IDLE` = 1'b1;
  - the default test pattern constant `SEQ_0110` = 4'b0110, shared with the detector bench.
- One natural sub-module: `piso_shift` (parallel-load, MSB-first shift register with `load` and `shift` enables, width WIDTH).
- Frame, bit and gap counters plus the FSM live in the top level.

## Test plan
- Reset, then `start`=1 at edge t with `pattern`=4'b0110 and `repeat_cnt`=0 → `out` = 0,1,1,0 in cycles t+1..t+4; `done`=1 in t+5; `out`=1 afterwards. In loopback into the detector, its `s` asserts exactly once.
- `pattern`=4'b0110, `repeat_cnt`=2, GAP_BITS=2 → 16 busy cycles with `out` = 0110 11 0110 11 0110; `done` in t+17.
- `start` re-asserted and `pattern` changed to 4'b1001 during cycles t+2..t+3 → stream unchanged; no second transfer begins.
- `rst`=1 in cycle t+2 of a frame → next cycle `out`=1, `busy`=0, `done`=0. No `done` pulse ever follows. A subsequent `start` transmits normally.
- `start` held high through the `done` cycle, `repeat_cnt`=0, two frames → second frame begins one cycle after `done`, with a single idle-high bit between the frames.
- `repeat_cnt`=4'hF, GAP_BITS=0 → exactly 16 frames (64 bits) back-to-back, then one `done` pulse.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the serial sequence transmitter/detector pair.
// State encoding, idle line level and the default test pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  localparam logic [3:0] SEQ_0110 = 4'b0110;

endpackage

// File: rtl/sequence_transmitter_piso_shift.sv
// Parallel-load, MSB-first shift register.
// Shifts in the fill bit so the line returns to idle once a frame drains.
module piso_shift
  import seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             fill,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= {WIDTH{LINE_IDLE}};
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], fill};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/sequence_transmitter.sv
// Serial pattern generator: repeats a latched pattern MSB-first,
// frames separated by idle-high gaps; line idles high.
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CNT_W    = 4,
  parameter int GAP_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t st, st_n;

  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] frames_q;
  logic [BW-1:0]    bit_q;
  logic [GW-1:0]    gap_q;

  logic accept;
  logic last_bit;
  logic last_gap;
  logic more;
  logic ld;
  logic sh;
  logic done_n;
  logic [WIDTH-1:0] ld_data;

  assign accept   = (st == IDLE) && start;
  assign last_bit = (st == SEND) && (bit_q == BIT_LAST);
  assign last_gap = (st == GAP) && (gap_q == GAP_LAST);
  assign more     = (frames_q != '0);
  assign ld_data  = accept ? pattern : pat_q;

  always_comb begin
    st_n   = st;
    ld     = 1'b0;
    sh     = 1'b0;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_n = SEND;
          ld   = 1'b1;
        end
      end
      SEND: begin
        if (!last_bit) begin
          sh = 1'b1;
        end else if (!more) begin
          st_n   = IDLE;
          sh     = 1'b1;
          done_n = 1'b1;
        end else if (GAP_BITS > 0) begin
          st_n = GAP;
          sh   = 1'b1;
        end else begin
          ld = 1'b1;
        end
      end
      GAP: begin
        if (last_gap) begin
          st_n = SEND;
          ld   = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      pat_q    <= '0;
      frames_q <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      st   <= st_n;
      busy <= (st_n != IDLE);
      done <= done_n;
      if (accept) begin
        pat_q    <= pattern;
        frames_q <= repeat_cnt;
      end
      if (st == SEND) begin
        bit_q <= last_bit ? '0 : bit_q + 1'b1;
      end
      if (st == GAP) begin
        gap_q <= last_gap ? '0 : gap_q + 1'b1;
      end
      // One frame finished with more to go: count it off.
      if (last_bit && more) begin
        frames_q <= frames_q - 1'b1;
      end
    end
  end

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .shift(sh),
    .fill (LINE_IDLE),
    .din  (ld_data),
    .msb  (out)
  );

endmodule

// File: tb/tb_sequence_transmitter.sv
// Bench: two transmitters (gap 2 and gap 0) against a
// queue-of-bits reference model under directed and random stimulus.
module tb_sequence_transmitter;
  import seq_pkg::*;

  localparam int W = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  pattern;
  logic [CW-1:0] repeat_cnt;
  logic          out_a, busy_a, done_a;
  logic          out_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  bit q_a[$];
  bit q_b[$];
  bit dn_a, dn_b;

  always #5 clk = ~clk;

  sequence_transmitter #(
    .WIDTH(W), .CNT_W(CW), .GAP_BITS(2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt),
    .out(out_a), .busy(busy_a), .done(done_a)
  );

  sequence_transmitter #(
    .WIDTH(W), .CNT_W(CW), .GAP_BITS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .pattern(pattern), .repeat_cnt(repeat_cnt),
    .out(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  // The whole transfer is a flat list of line bits, built from the
  // request; one bit is consumed per clock.
  task automatic model_edge(
    inout bit q[$],
    inout bit dn,
    input int gap
  );
    bit was_busy;
    if (rst) begin
      q.delete();
      dn = 1'b0;
    end else begin
      was_busy = (q.size() != 0);
      dn = 1'b0;
      if (was_busy) begin
        void'(q.pop_front());
        if (q.size() == 0) dn = 1'b1;
      end
      if (!was_busy && start) begin
        for (int f = 0; f <= int'(repeat_cnt); f++) begin
          for (int b = W - 1; b >= 0; b--) q.push_back(pattern[b]);
          if (f < int'(repeat_cnt))
            for (int g = 0; g < gap; g++) q.push_back(1'b1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(q_a, dn_a, 2);
    model_edge(q_b, dn_b, 0);
    #1;
    check("a_out",  out_a,  (q_a.size() != 0) ? q_a[0] : LINE_IDLE);
    check("a_busy", busy_a, q_a.size() != 0);
    check("a_done", done_a, dn_a);
    check("b_out",  out_b,  (q_b.size() != 0) ? q_b[0] : LINE_IDLE);
    check("b_busy", busy_b, q_b.size() != 0);
    check("b_done", done_b, dn_b);
  endtask

  task automatic req(
    input logic [W-1:0] p,
    input logic [CW-1:0] rc
  );
    start = 1'b1;
    pattern = p;
    repeat_cnt = rc;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_done;

  initial begin
    rst = 1'b1;
    start = 1'b1;
    pattern = SEQ_0110;
    repeat_cnt = '0;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    idle(2);

    // Single frame, then three frames with gaps.
    req(SEQ_0110, 4'd0);
    idle(8);
    req(SEQ_0110, 4'd2);
    idle(20);

    // Re-request and pattern change while busy are ignored.
    req(SEQ_0110, 4'd0);
    start = 1'b1;
    pattern = 4'b1001;
    repeat_cnt = 4'd3;
    tick();
    tick();
    idle(6);

    // Reset in the middle of a frame, then a clean transfer.
    req(SEQ_0110, 4'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(4);
    req(4'b1011, 4'd0);
    idle(6);

    // Start held through the done cycle.
    start = 1'b1;
    pattern = SEQ_0110;
    repeat_cnt = 4'd0;
    for (int i = 0; i < 11; i++) tick();
    idle(6);

    // All-ones repeat count: sixteen frames.
    n_done = 0;
    req(SEQ_0110, 4'hF);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_b) n_done++;
    end
    check("b_rep16_done_cnt", n_done, 1);

    // Random traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      pattern = W'($urandom);
      repeat_cnt = ($urandom_range(0, 15) == 0) ? 4'hF
                   : CW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0;
    idle(120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
